fetch_unit: RTL

Instruction-fetch stage of the pipelined RV32 core. Owns the program counter, issues single-word requests to instruction memory over a valid/ready handshake, and delivers each returned instruction with its PC into the IF/ID register consumed by decode. Handles backpressure from decode with a one-entry skid buffer and discards in-flight fetches on a control-flow redirect from execute.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 26 ++
 rtl/fetch_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_REQ  = 2'd0;
  localparam fetch_state_t ST_WAIT = 2'd1;
  localparam fetch_state_t ST_HOLD = 2'd2;
  localparam fetch_state_t ST_DROP = 2'd3;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [31:0]     instr;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{pc: '0, pc_plus4: '0, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - payload register with valid flag; load wins over flush
module if_id_reg
  import fetch_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   flush,
  input  if_id_t din,
  output logic   valid,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      q     <= IF_ID_RESET;
    end else if (load) begin
      valid <= 1'b1;
      q     <= din;
    end else if (flush) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch stage: PC, imem handshake, IF/ID + skid; IF_PERF_CNT_EN adds perf counters
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [31:0]     id_instr
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_flushes
`endif
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic            if_id_free;
  logic            out_load, out_flush, skid_load, skid_flush, skid_valid;
  if_id_t          fetch_word, out_din, out_q, skid_q;

  assign pc_plus4   = pc_q + XLEN'(4);
  assign if_id_free = !id_valid || id_ready;

  assign fetch_word.pc       = pc_q;
  assign fetch_word.pc_plus4 = pc_plus4;
  assign fetch_word.instr    = imem_rsp_data;

  // Request side depends only on registered state so memory sees no input-to-output path.
  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    out_din    = fetch_word;
    out_load   = 1'b0;
    out_flush  = id_valid && id_ready;
    skid_load  = 1'b0;
    skid_flush = 1'b0;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
      out_flush  = 1'b1;
      skid_flush = 1'b1;
      // Go to DROP only if a response is still owed to us after this edge.
      if ((state_q == ST_REQ && imem_req_ready) ||
          ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rsp_valid))
        state_d = ST_DROP;
      else
        state_d = ST_REQ;
    end else begin
      case (state_q)
        ST_REQ: begin
          if (imem_req_ready)
            state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            pc_d = pc_plus4;
            if (if_id_free) begin
              out_load = 1'b1;
              state_d  = ST_REQ;
            end else begin
              skid_load = 1'b1;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (id_ready && skid_valid) begin
            out_din    = skid_q;
            out_load   = 1'b1;
            skid_flush = 1'b1;
            state_d    = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_rsp_valid)
            state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg u_out (
    .clk   (clk),
    .rst   (rst),
    .load  (out_load),
    .flush (out_flush),
    .din   (out_din),
    .valid (id_valid),
    .q     (out_q)
  );

  if_id_reg u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load),
    .flush (skid_flush),
    .din   (fetch_word),
    .valid (skid_valid),
    .q     (skid_q)
  );

  assign id_pc       = out_q.pc;
  assign id_pc_plus4 = out_q.pc_plus4;
  assign id_instr    = out_q.instr;

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_flushes <= '0;
    end else begin
      if (id_valid && id_ready)
        perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid)
        perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule
